fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the pipelined RV32 core. Owns the program counter and drives the instruction memory's combinational read port, then latches the returned word with its PC into the IF/ID pipeline register for decode. Handles hazard-unit stalls, control-flow redirects from EX (taken branch, JAL, JALR), and squashing of wrong-path instructions. Also keeps a sticky misaligned-target flag and a fetched-instruction counter for debug.

---
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem read port
// and latches the returned word with its PC into the IF/ID pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall_f,
   input  logic        flush_d,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic        misalign_fault,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] pc_next;
   logic        capture;
   logic [31:0] instr_q;
   logic [31:0] id_pc_q;
   logic [31:0] id_pc_plus4_q;
   logic        valid_q;
   logic        fault_q;
   logic [31:0] fetch_count_q;

   assign pc_plus4 = pc_q + 32'd4;

   // Stall/flush/redirect are level controls sampled at posedge; there is no
   // valid/ready handshake, and a redirect always beats a stall.
   always_comb begin
      pc_next = pc_plus4;
      if (redirect_valid) begin
         pc_next = {redirect_target[31:2], 2'b00};
      end else if (stall_f) begin
         pc_next = pc_q;
      end
   end

   assign capture = !flush_d && !redirect_valid && !stall_f;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         instr_q       <= NOP;
         id_pc_q       <= 32'd0;
         id_pc_plus4_q <= 32'd0;
         valid_q       <= 1'b0;
         fault_q       <= 1'b0;
         fetch_count_q <= 32'd0;
      end else begin
         pc_q <= pc_next;
         // A squash keeps the old PC fields so debug still sees where it was.
         if (flush_d || redirect_valid) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
         end else if (capture) begin
            instr_q       <= imem_rdata;
            id_pc_q       <= pc_q;
            id_pc_plus4_q <= pc_plus4;
            valid_q       <= 1'b1;
            fetch_count_q <= fetch_count_q + 32'd1;
         end
         if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
         end
      end
   end

   assign imem_addr      = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc       = id_pc_q;
   assign if_id_pc_plus4 = id_pc_plus4_q;
   assign if_id_valid    = valid_q;
   assign misalign_fault = fault_q;
   assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control traffic
// compared cycle by cycle against a behavioural pipeline model.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // ---------------- clock / reset / DUT ----------------
   logic        clk;
   logic        rst_n, stall_f, flush_d, redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
   logic        if_id_valid, misalign_fault;

   logic        rst2_n, zero_bit;
   logic [31:0] zero_word;
   logic [31:0] imem_addr2, imem_rdata2;
   logic [31:0] if_id_instr2, if_id_pc2, if_id_pc_plus42, fetch_count2;
   logic        if_id_valid2, misalign_fault2;

   logic [31:0] mem [256];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign imem_rdata  = mem[imem_addr[9:2]];
   assign imem_rdata2 = mem[imem_addr2[9:2]];

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall_f(stall_f), .flush_d(flush_d), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .if_id_instr(if_id_instr),
      .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
      .if_id_valid(if_id_valid), .misalign_fault(misalign_fault),
      .fetch_count(fetch_count)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst2_n), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .stall_f(zero_bit), .flush_d(zero_bit), .redirect_valid(zero_bit),
      .redirect_target(zero_word), .if_id_instr(if_id_instr2),
      .if_id_pc(if_id_pc2), .if_id_pc_plus4(if_id_pc_plus42),
      .if_id_valid(if_id_valid2), .misalign_fault(misalign_fault2),
      .fetch_count(fetch_count2)
   );

   // ---------------- reference model ----------------
   int          n_vec;
   int          n_err;
   logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_count;
   logic        m_valid, m_fault;

   // The model keeps the pipeline as "the PC being fetched" plus "the slot
   // handed to decode"; each edge either restarts, squashes, freezes or advances.
   task automatic model_edge(input logic r, input logic s, input logic f,
                             input logic rv, input logic [31:0] t);
      logic [31:0] fetched;
      if (!r) begin
         m_pc = 32'h0; m_instr = NOP; m_id_pc = 0; m_id_pc4 = 0;
         m_valid = 0; m_fault = 0; m_count = 0;
         return;
      end
      fetched = mem[m_pc[9:2]];
      if (rv || f) begin
         m_instr = NOP;
         m_valid = 0;
      end else if (!s) begin
         m_instr  = fetched;
         m_id_pc  = m_pc;
         m_id_pc4 = m_pc + 4;
         m_valid  = 1;
         m_count  = m_count + 1;
      end
      if (rv) begin
         if (t % 4 != 0) m_fault = 1;
         m_pc = t - (t % 4);
      end else if (!s) begin
         m_pc = m_pc + 4;
      end
   endtask

   // ---------------- driver ----------------
   // Called at a negedge: apply inputs, let one posedge pass, return at the next negedge.
   task automatic step(input logic r, input logic s, input logic f,
                       input logic rv, input logic [31:0] t);
      rst_n = r; stall_f = s; flush_d = f; redirect_valid = rv; redirect_target = t;
      @(posedge clk);
      model_edge(r, s, f, rv, t);
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      step(0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 32'h44);
      n_vec++;
      if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h exp %h", imem_addr, 32'h0); end
      n_vec++;
      if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
      n_vec++;
      if (if_id_instr !== NOP) begin n_err++; $display("FAIL reset_instr got %h exp %h", if_id_instr, NOP); end
      n_vec++;
      if ({if_id_pc, if_id_pc_plus4, fetch_count} !== 96'h0 || misalign_fault !== 1'b0) begin
         n_err++; $display("FAIL reset_regs got pc %h pc4 %h cnt %h flt %b exp zeros",
                           if_id_pc, if_id_pc_plus4, fetch_count, misalign_fault);
      end
   endtask

   task automatic test_seq_fetch;
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (imem_addr !== 32'h4) begin n_err++; $display("FAIL seq_addr4 got %h exp %h", imem_addr, 32'h4); end
      n_vec++;
      if (if_id_pc !== 32'h0 || if_id_instr !== 32'h0000_0513 || if_id_valid !== 1'b1) begin
         n_err++; $display("FAIL seq_first got pc %h instr %h v %b exp pc 0 instr 00000513 v 1",
                           if_id_pc, if_id_instr, if_id_valid);
      end
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (imem_addr !== 32'h8 || if_id_pc !== 32'h4) begin
         n_err++; $display("FAIL seq_second got addr %h pc %h exp addr 8 pc 4", imem_addr, if_id_pc);
      end
   endtask

   task automatic test_stall;
      for (int i = 0; i < 2; i++) begin
         step(1, 1, 0, 0, 0);
         n_vec++;
         if (imem_addr !== 32'h8 || if_id_pc !== 32'h4 || if_id_instr !== 32'h07B0_0593 || fetch_count !== 32'd2) begin
            n_err++; $display("FAIL stall_hold got addr %h pc %h instr %h cnt %0d exp addr 8 pc 4 instr 07b00593 cnt 2",
                              imem_addr, if_id_pc, if_id_instr, fetch_count);
         end
      end
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (imem_addr !== 32'hC || if_id_pc !== 32'h8 || fetch_count !== 32'd3) begin
         n_err++; $display("FAIL stall_resume got addr %h pc %h cnt %0d exp addr c pc 8 cnt 3",
                           imem_addr, if_id_pc, fetch_count);
      end
   endtask

   task automatic test_jal_redirect;
      while (m_pc != 32'h1C) step(1, 0, 0, 0, 0);
      n_vec++;
      if (imem_addr !== 32'h1C) begin n_err++; $display("FAIL jal_pre got %h exp %h", imem_addr, 32'h1C); end
      step(1, 0, 0, 1, 32'h3C);
      n_vec++;
      if (imem_addr !== 32'h3C || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
         n_err++; $display("FAIL jal_squash got addr %h v %b instr %h exp addr 3c v 0 instr 00000013",
                           imem_addr, if_id_valid, if_id_instr);
      end
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (if_id_pc !== 32'h3C || if_id_instr !== 32'h0646_8693 || if_id_pc_plus4 !== 32'h40 || if_id_valid !== 1'b1) begin
         n_err++; $display("FAIL jal_target got pc %h instr %h pc4 %h v %b exp pc 3c instr 06468693 pc4 40 v 1",
                           if_id_pc, if_id_instr, if_id_pc_plus4, if_id_valid);
      end
   endtask

   task automatic test_stall_redirect;
      step(1, 1, 0, 1, 32'h8C);
      n_vec++;
      if (imem_addr !== 32'h8C || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
         n_err++; $display("FAIL stall_redir got addr %h v %b instr %h exp addr 8c v 0 instr 00000013",
                           imem_addr, if_id_valid, if_id_instr);
      end
   endtask

   task automatic test_misalign;
      step(1, 0, 0, 1, 32'h8E);
      n_vec++;
      if (imem_addr !== 32'h8C || misalign_fault !== 1'b1) begin
         n_err++; $display("FAIL misalign got addr %h flt %b exp addr 8c flt 1", imem_addr, misalign_fault);
      end
      for (int i = 0; i < 10; i++) begin
         step(1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 1'b0, 32'h0);
         n_vec++;
         if (misalign_fault !== 1'b1 || imem_addr !== m_pc) begin
            n_err++; $display("FAIL misalign_sticky cyc %0d got flt %b addr %h exp flt 1 addr %h",
                              i, misalign_fault, imem_addr, m_pc);
         end
      end
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (misalign_fault !== 1'b0) begin n_err++; $display("FAIL misalign_clear got %b exp 0", misalign_fault); end
   endtask

   task automatic test_random;
      logic        r, s, f, rv;
      logic [31:0] t;
      for (int i = 0; i < 300; i++) begin
         r  = ($urandom_range(0, 40) != 0);
         s  = ($urandom_range(0, 3) == 0);
         f  = ($urandom_range(0, 7) == 0);
         rv = ($urandom_range(0, 6) == 0);
         t  = {22'h0, 10'($urandom_range(0, 1023))};
         step(r, s, f, rv, t);
         n_vec++;
         if (imem_addr !== m_pc || if_id_instr !== m_instr || if_id_pc !== m_id_pc ||
             if_id_pc_plus4 !== m_id_pc4 || if_id_valid !== m_valid ||
             misalign_fault !== m_fault || fetch_count !== m_count) begin
            n_err++;
            $display("FAIL random cyc %0d got addr %h instr %h pc %h pc4 %h v %b flt %b cnt %0d exp addr %h instr %h pc %h pc4 %h v %b flt %b cnt %0d",
                     i, imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, misalign_fault, fetch_count,
                     m_pc, m_instr, m_id_pc, m_id_pc4, m_valid, m_fault, m_count);
         end
      end
   endtask

   task automatic test_count_wrap;
      step(1, 0, 0, 0, 0);
      force dut.fetch_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_count_q;
      m_count = 32'hFFFF_FFFF;
      n_vec++;
      if (fetch_count !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL count_preload got %h exp ffffffff", fetch_count);
      end
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (fetch_count !== 32'h0 || fetch_count !== m_count) begin
         n_err++; $display("FAIL count_wrap got %h exp 00000000", fetch_count);
      end
   endtask

   task automatic test_pc_wrap;
      rst2_n = 1'b0;
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (imem_addr2 !== 32'hFFFF_FFFC) begin
         n_err++; $display("FAIL wrap_reset got %h exp fffffffc", imem_addr2);
      end
      rst2_n = 1'b1;
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (imem_addr2 !== 32'h0 || misalign_fault2 !== 1'b0 || if_id_pc2 !== 32'hFFFF_FFFC ||
          if_id_pc_plus42 !== 32'h0 || if_id_valid2 !== 1'b1 || if_id_instr2 !== mem[255]) begin
         n_err++; $display("FAIL wrap_pc got addr %h flt %b pc %h pc4 %h v %b instr %h exp addr 0 flt 0 pc fffffffc pc4 0 v 1 instr %h",
                           imem_addr2, misalign_fault2, if_id_pc2, if_id_pc_plus42, if_id_valid2, if_id_instr2, mem[255]);
      end
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (imem_addr2 !== 32'h4 || if_id_pc2 !== 32'h0 || fetch_count2 !== 32'd2) begin
         n_err++; $display("FAIL wrap_next got addr %h pc %h cnt %0d exp addr 4 pc 0 cnt 2",
                           imem_addr2, if_id_pc2, fetch_count2);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_vec = 0; n_err = 0;
      zero_bit = 1'b0; zero_word = 32'h0; rst2_n = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0]  = 32'h0000_0513;
      mem[1]  = 32'h07B0_0593;
      mem[15] = 32'h0646_8693;
      m_pc = 0; m_instr = NOP; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0; m_fault = 0; m_count = 0;
      test_reset;
      test_seq_fetch;
      test_stall;
      test_jal_redirect;
      test_stall_redirect;
      test_misalign;
      test_random;
      test_count_wrap;
      test_pc_wrap;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
